// File: rtl/mem_port_arbiter_if.sv
// Bundled core-side (I and D) and memory-side signals for mem_port_arbiter.
// The arbiter takes the slave modport; the core/memory environment takes master.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (I) and data (D) ports; D wins
// unless it has won MAX_D_STREAK times in a row with I waiting. Macro ARB_PERF_EN adds wait counters.
module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic [31:0]         i_wait_cnt,
    output logic [31:0]         d_wait_cnt
);
    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] MaxStreak = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.d_req && (streak_q < MaxStreak || !bus.i_req)) begin
                    state_d   = StBusyD;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    // Streak only grows while I is actually being held off
                    if (!bus.i_req) begin
                        streak_d = '0;
                    end else if (streak_q != MaxStreak) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (bus.i_req) begin
                    state_d   = StBusyI;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = '0;
                    streak_d  = '0;
                end
            end
            StBusyI: begin
                if (bus.m_ack) begin
                    m_req_d   = 1'b0;
                    i_rdata_d = bus.m_rdata;
                    i_ready_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StBusyD: begin
                if (bus.m_ack) begin
                    m_req_d = 1'b0;
                    // Writes leave the previous read data in place
                    if (!m_we_q) begin
                        d_rdata_d = bus.m_rdata;
                    end
                    d_ready_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            streak_q  <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ready = i_ready_q;
    assign bus.d_ready = d_ready_q;

`ifdef ARB_PERF_EN
    logic [31:0] i_wait_q, d_wait_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_wait_q <= '0;
            d_wait_q <= '0;
        end else begin
            if (bus.i_req && !i_ready_q) i_wait_q <= i_wait_q + 32'd1;
            if (bus.d_req && !d_ready_q) d_wait_q <= d_wait_q + 32'd1;
        end
    end

    assign i_wait_cnt = i_wait_q;
    assign d_wait_cnt = d_wait_q;
`else
    assign i_wait_cnt = 32'd0;
    assign d_wait_cnt = 32'd0;
`endif

endmodule
